// File: rtl/mio_bus_bridge_pkg.sv
// mio_bus_bridge_pkg
//  Shared definitions for the memory/IO bridge:
//   - region codes produced by the address decoder
//   - bridge FSM state encoding
//   - address-map nibble constants (addr[31:28])
//   - decode_region helper used by the address decoder
package mio_bus_bridge_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_GPIO = 2'd1,
    REG_CNT  = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] MAP_RAM  = 4'h0;
  localparam logic [3:0] MAP_GPIO = 4'hE;
  localparam logic [3:0] MAP_CNT  = 4'hF;

  // Largest wait count the 4-bit wait counter can hold.
  localparam int WAIT_MAX = 15;

  function automatic region_t decode_region(input logic [3:0] nib);
    case (nib)
      MAP_RAM:  decode_region = REG_RAM;
      MAP_GPIO: decode_region = REG_GPIO;
      MAP_CNT:  decode_region = REG_CNT;
      default:  decode_region = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mio_bus_bridge_if.sv
// mio_bus_bridge_if
//  Requester-side bus between the multi-cycle controller and the bridge.
//   mem_r, mem_w   level read/write requests, held until mio_ready
//   addr, wdata    byte address and write data
//   rdata          read data returned by the bridge
//   mio_ready      one-cycle completion pulse
//   bus_err        one-cycle error pulse, coincident with mio_ready
//  modport master: the requester; modport slave: the bridge.
interface mio_bus_bridge_if;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mio_ready;
  logic        bus_err;

  modport master (
    output mem_r, mem_w, addr, wdata,
    input  rdata, mio_ready, bus_err
  );

  modport slave (
    input  mem_r, mem_w, addr, wdata,
    output rdata, mio_ready, bus_err
  );
endinterface

// File: rtl/mio_bus_bridge_addr_decode.sv
// mio_bus_bridge_addr_decode
//  Combinational region decoder for the memory/IO bridge.
//  Ports:
//   addr_nib  in   4  address bits [31:28]
//   region    out  2  region code (RAM / GPIO / counter / none)
//   wait_cnt  out  4  extra BUSY cycles for that region
module mio_bus_bridge_addr_decode
  import mio_bus_bridge_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 0
) (
  input  logic [3:0] addr_nib,
  output region_t    region,
  output logic [3:0] wait_cnt
);

  localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
  localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

  // Unmapped accesses get no wait states so the error returns quickly.
  always_comb begin
    region = decode_region(addr_nib);
    case (region)
      REG_RAM:           wait_cnt = RAM_WAIT_C;
      REG_GPIO, REG_CNT: wait_cnt = IO_WAIT_C;
      default:           wait_cnt = 4'd0;
    endcase
  end

endmodule

// File: rtl/mio_bus_bridge.sv
// mio_bus_bridge
//  Memory/IO bridge downstream of the multi-cycle controller. Converts a held
//  level request into exactly one region-decoded access (synchronous RAM, GPIO
//  or counter), inserts per-region wait states and returns rdata with a
//  one-cycle mio_ready pulse (plus bus_err on unmapped/conflicting requests).
//  Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   bus (slave modport)   mem_r, mem_w, addr, wdata, rdata, mio_ready, bus_err
//   ram_addr/we/wdata     RAM word address, write strobe, write data
//   ram_rdata             RAM data, valid the cycle after ram_addr
//   gpio_we, gpio_rdata   GPIO write strobe, combinational read value
//   cnt_we, cnt_rdata     counter write strobe, combinational read value
//  Peripherals take their write data from ram_wdata (the latched wdata).
module mio_bus_bridge
  import mio_bus_bridge_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 0,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_bridge_if.slave   bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              gpio_we,
  input  logic [31:0]       gpio_rdata,
  output logic              cnt_we,
  input  logic [31:0]       cnt_rdata
);

  if (RAM_WAIT < 0 || RAM_WAIT > WAIT_MAX || IO_WAIT < 0 || IO_WAIT > WAIT_MAX) begin : g_bad_wait
    $error("mio_bus_bridge: RAM_WAIT and IO_WAIT must be in 0..15");
  end
  if (RAM_AW < 1 || RAM_AW > 29) begin : g_bad_aw
    $error("mio_bus_bridge: RAM_AW must be in 1..29");
  end

  state_t      state;
  logic [3:0]  wcnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        op_write_q;
  logic        conflict_q;
  region_t     region_q;

  logic        ram_we_q;
  logic        gpio_we_q;
  logic        cnt_we_q;
  logic        ready_q;
  logic        err_q;

  region_t     dec_region;
  logic [3:0]  dec_wait;
  logic [31:0] src_rdata;
  logic        fire_write;
  region_t     fire_region;
  logic        busy_last;
  logic        unused_addr_bits;

  mio_bus_bridge_addr_decode #(
    .RAM_WAIT (RAM_WAIT),
    .IO_WAIT  (IO_WAIT)
  ) u_decode (
    .addr_nib (bus.addr[31:28]),
    .region   (dec_region),
    .wait_cnt (dec_wait)
  );

  // Final BUSY cycle: the access itself happens here and DONE follows.
  assign busy_last = (state == ST_BUSY) && (wcnt == 4'd0);

  // Decide whether the next cycle is the final BUSY cycle of a write, so the
  // strobe register is high for exactly that cycle. With zero wait states the
  // final BUSY cycle directly follows IDLE, so the decoder output is used.
  always_comb begin
    fire_write  = 1'b0;
    fire_region = region_q;
    case (state)
      ST_IDLE: begin
        if (bus.mem_w && dec_wait == 4'd0) begin
          fire_write  = 1'b1;
          fire_region = dec_region;
        end
      end
      ST_BUSY: begin
        if (op_write_q && wcnt == 4'd1) begin
          fire_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Read source for the latched region; RAM data arrives one cycle after the
  // address, which lines up with DONE.
  always_comb begin
    case (region_q)
      REG_RAM:  src_rdata = ram_rdata;
      REG_GPIO: src_rdata = gpio_rdata;
      REG_CNT:  src_rdata = cnt_rdata;
      default:  src_rdata = 32'd0;
    endcase
  end

  // Bridge FSM with registered strobes, ready and error. RELEASE waits for the
  // requester to drop both lines so a held request is served only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wcnt       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      op_write_q <= 1'b0;
      conflict_q <= 1'b0;
      region_q   <= REG_NONE;
      ram_we_q   <= 1'b0;
      gpio_we_q  <= 1'b0;
      cnt_we_q   <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ram_we_q  <= fire_write && (fire_region == REG_RAM);
      gpio_we_q <= fire_write && (fire_region == REG_GPIO);
      cnt_we_q  <= fire_write && (fire_region == REG_CNT);
      ready_q   <= busy_last;
      err_q     <= busy_last && (conflict_q || region_q == REG_NONE);
      case (state)
        ST_IDLE: begin
          if (bus.mem_r || bus.mem_w) begin
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
            op_write_q <= bus.mem_w;
            conflict_q <= bus.mem_r && bus.mem_w;
            region_q   <= dec_region;
            wcnt       <= dec_wait;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          rdata_q <= src_rdata;
          state   <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!bus.mem_r && !bus.mem_w) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mio_ready = ready_q;
  assign bus.bus_err   = err_q;
  assign bus.rdata     = (state == ST_DONE) ? src_rdata : rdata_q;

  assign ram_addr  = (state == ST_BUSY || state == ST_DONE) ? addr_q[RAM_AW+1:2] : '0;
  assign ram_we    = ram_we_q;
  assign ram_wdata = wdata_q;
  assign gpio_we   = gpio_we_q;
  assign cnt_we    = cnt_we_q;

  // Byte-offset bits and bits above the RAM window only matter for decode.
  assign unused_addr_bits = ^{addr_q[1:0], addr_q[31:RAM_AW+2]};

endmodule

// File: tb/tb_mio_bus_bridge.sv
// tb_mio_bus_bridge
//  Self-checking bench for mio_bus_bridge (RAM_WAIT=1, IO_WAIT=0, RAM_AW=10).
//  Provides a synchronous RAM, a GPIO register and a counter register, and
//  predicts latency, errors, strobes and read data from the address map.
module tb_mio_bus_bridge;
  localparam int RAM_WAIT = 1;
  localparam int IO_WAIT  = 0;
  localparam int RAM_AW   = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mio_bus_bridge_if bus();

  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              gpio_we;
  logic [31:0]       gpio_rdata;
  logic              cnt_we;
  logic [31:0]       cnt_rdata;

  mio_bus_bridge #(
    .RAM_WAIT (RAM_WAIT),
    .IO_WAIT  (IO_WAIT),
    .RAM_AW   (RAM_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .gpio_we    (gpio_we),
    .gpio_rdata (gpio_rdata),
    .cnt_we     (cnt_we),
    .cnt_rdata  (cnt_rdata)
  );

  // Peripherals attached to the bridge
  logic [31:0] ram_mem [0:(1<<RAM_AW)-1];
  logic [31:0] gpio_reg = 32'd0;
  logic [31:0] cnt_reg  = 32'd0;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end
  always @(posedge clk) if (gpio_we) gpio_reg <= ram_wdata;
  always @(posedge clk) if (cnt_we) cnt_reg <= ram_wdata;
  assign gpio_rdata = gpio_reg;
  assign cnt_rdata  = cnt_reg;

  // Strobe / pulse monitor
  int                n_ram_we = 0;
  int                n_gpio_we = 0;
  int                n_cnt_we = 0;
  int                n_ready = 0;
  logic [RAM_AW-1:0] we_addr = '0;
  logic [31:0]       we_data = '0;

  always @(negedge clk) begin
    if (ram_we) begin
      n_ram_we++;
      we_addr = ram_addr;
      we_data = ram_wdata;
    end
    if (gpio_we) n_gpio_we++;
    if (cnt_we) n_cnt_we++;
    if (bus.mio_ready) n_ready++;
  end

  // Reference state
  logic [31:0] exp_ram [0:(1<<RAM_AW)-1];
  bit          exp_vld [0:(1<<RAM_AW)-1];
  logic [31:0] exp_gpio = 32'd0;
  logic [31:0] exp_cnt  = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int region_of(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 0;
      4'hE:    return 1;
      4'hF:    return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int latency_of(input logic [31:0] a);
    int r;
    r = region_of(a);
    if (r == 0) return RAM_WAIT + 2;
    if (r == 3) return 2;
    return IO_WAIT + 2;
  endfunction

  // One complete request: raise lines, wait for mio_ready (bounded), sample
  // rdata one cycle after the pulse, hold `hold` more cycles, then release.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int hold,
                           output logic [31:0] rdv, output logic [31:0] rdv_after,
                           output logic errv, output int lat);
    @(negedge clk);
    bus.mem_r = rd;
    bus.mem_w = wr;
    bus.addr  = a;
    bus.wdata = d;
    lat = 0;
    rdv = 32'd0;
    errv = 1'b0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.mio_ready || lat >= 40) break;
    end
    if (!bus.mio_ready) lat = -1;
    rdv  = bus.rdata;
    errv = bus.bus_err;
    @(negedge clk);
    rdv_after = bus.rdata;
    repeat (hold) @(negedge clk);
    bus.mem_r = 1'b0;
    bus.mem_w = 1'b0;
    bus.addr  = $urandom;
    bus.wdata = $urandom;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_r = 1'b0;
    bus.mem_w = 1'b0;
    bus.addr = 32'd0;
    bus.wdata = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.rdata !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.rdata);
    end
    n_checks++;
    if ({bus.mio_ready, bus.bus_err} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL reset_ready_err: got %b expected 00", {bus.mio_ready, bus.bus_err});
    end
    n_checks++;
    if ({ram_we, gpio_we, cnt_we} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_strobes: got %b expected 000", {ram_we, gpio_we, cnt_we});
    end
    n_checks++;
    if (ram_addr !== '0) begin
      n_fail++; $display("[TB] FAIL reset_ram_addr: got %h expected 0", ram_addr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ram_write_read();
    logic [31:0] rdv, rdv_after;
    logic errv;
    int lat, s_ram;
    s_ram = n_ram_we;
    do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, rdv, rdv_after, errv, lat);
    exp_ram[4] = 32'hDEAD_BEEF; exp_vld[4] = 1'b1;
    n_checks++;
    if (lat !== RAM_WAIT + 2) begin
      n_fail++; $display("[TB] FAIL ram_wr_latency: got %0d expected %0d", lat, RAM_WAIT + 2);
    end
    n_checks++;
    if (n_ram_we - s_ram !== 1) begin
      n_fail++; $display("[TB] FAIL ram_wr_strobe_count: got %0d expected 1", n_ram_we - s_ram);
    end
    n_checks++;
    if (we_addr !== 10'd4 || we_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL ram_wr_addr_data: got %h/%h expected 004/deadbeef", we_addr, we_data);
    end
    n_checks++;
    if (errv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ram_wr_err: got %b expected 0", errv);
    end
    s_ram = n_ram_we;
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, rdv, rdv_after, errv, lat);
    n_checks++;
    if (rdv !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL ram_rd_data: got %h expected deadbeef", rdv);
    end
    n_checks++;
    if (rdv_after !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL ram_rd_held: got %h expected deadbeef", rdv_after);
    end
    n_checks++;
    if (lat !== RAM_WAIT + 2 || n_ram_we != s_ram) begin
      n_fail++; $display("[TB] FAIL ram_rd_latency_strobe: got lat %0d we %0d expected %0d 0", lat, n_ram_we - s_ram, RAM_WAIT + 2);
    end
  endtask

  task automatic test_gpio_cnt();
    logic [31:0] rdv, rdv_after, cval;
    logic errv;
    int lat, s_gpio, s_ram;
    s_gpio = n_gpio_we;
    s_ram = n_ram_we;
    do_access(1'b0, 1'b1, 32'hE000_0000, 32'h0000_0005, 0, rdv, rdv_after, errv, lat);
    exp_gpio = 32'h5;
    n_checks++;
    if (lat !== IO_WAIT + 2) begin
      n_fail++; $display("[TB] FAIL gpio_wr_latency: got %0d expected %0d", lat, IO_WAIT + 2);
    end
    n_checks++;
    if (n_gpio_we - s_gpio !== 1 || n_ram_we != s_ram) begin
      n_fail++; $display("[TB] FAIL gpio_wr_strobes: got gpio %0d ram %0d expected 1 0", n_gpio_we - s_gpio, n_ram_we - s_ram);
    end
    do_access(1'b1, 1'b0, 32'hE000_0000, 32'h0, 0, rdv, rdv_after, errv, lat);
    n_checks++;
    if (rdv !== exp_gpio) begin
      n_fail++; $display("[TB] FAIL gpio_rd_data: got %h expected %h", rdv, exp_gpio);
    end
    cval = $urandom;
    do_access(1'b0, 1'b1, 32'hF000_0000, cval, 0, rdv, rdv_after, errv, lat);
    exp_cnt = cval;
    do_access(1'b1, 1'b0, 32'hF000_0000, 32'h0, 0, rdv, rdv_after, errv, lat);
    n_checks++;
    if (rdv !== exp_cnt || lat !== IO_WAIT + 2) begin
      n_fail++; $display("[TB] FAIL cnt_rd: got %h lat %0d expected %h lat %0d", rdv, lat, exp_cnt, IO_WAIT + 2);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rdv, rdv_after;
    logic errv;
    int lat, s_all;
    s_all = n_ram_we + n_gpio_we + n_cnt_we;
    do_access(1'b1, 1'b0, 32'h4000_0000, 32'h0, 0, rdv, rdv_after, errv, lat);
    n_checks++;
    if (rdv !== 32'd0 || errv !== 1'b1) begin
      n_fail++; $display("[TB] FAIL none_rd: got rdata %h err %b expected 0 1", rdv, errv);
    end
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("[TB] FAIL none_latency: got %0d expected 2", lat);
    end
    do_access(1'b0, 1'b1, 32'h8000_0040, $urandom, 0, rdv, rdv_after, errv, lat);
    n_checks++;
    if (n_ram_we + n_gpio_we + n_cnt_we != s_all || errv !== 1'b1) begin
      n_fail++; $display("[TB] FAIL none_wr: got strobes %0d err %b expected 0 1", n_ram_we + n_gpio_we + n_cnt_we - s_all, errv);
    end
  endtask

  task automatic test_hold_no_repeat();
    logic [31:0] rdv, rdv_after;
    logic errv;
    int lat, s_ready;
    s_ready = n_ready;
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 6, rdv, rdv_after, errv, lat);
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_ready - s_ready !== 1) begin
      n_fail++; $display("[TB] FAIL hold_ready_count: got %0d expected 1", n_ready - s_ready);
    end
    s_ready = n_ready;
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, rdv, rdv_after, errv, lat);
    n_checks++;
    if (lat !== RAM_WAIT + 2 || rdv !== exp_ram[4] || n_ready - s_ready !== 1) begin
      n_fail++; $display("[TB] FAIL hold_next_access: got lat %0d data %h expected %0d %h", lat, rdv, RAM_WAIT + 2, exp_ram[4]);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] rdv, rdv_after, v;
    logic errv;
    int lat, s_gpio;
    v = $urandom;
    s_gpio = n_gpio_we;
    do_access(1'b1, 1'b1, 32'hE000_0100, v, 0, rdv, rdv_after, errv, lat);
    exp_gpio = v;
    n_checks++;
    if (errv !== 1'b1 || n_gpio_we - s_gpio !== 1) begin
      n_fail++; $display("[TB] FAIL conflict_write: got err %b strobes %0d expected 1 1", errv, n_gpio_we - s_gpio);
    end
    do_access(1'b1, 1'b0, 32'hE000_0000, 32'h0, 0, rdv, rdv_after, errv, lat);
    n_checks++;
    if (rdv !== exp_gpio || errv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL conflict_readback: got %h err %b expected %h 0", rdv, errv, exp_gpio);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rdv, rdv_after, v_old;
    logic errv;
    int lat, s_ram;
    v_old = $urandom | 32'h1;
    do_access(1'b0, 1'b1, 32'h0000_0020, v_old, 0, rdv, rdv_after, errv, lat);
    exp_ram[8] = v_old; exp_vld[8] = 1'b1;
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, rdv, rdv_after, errv, lat);
    s_ram = n_ram_we;
    @(negedge clk);
    bus.mem_w = 1'b1;
    bus.addr  = 32'h0000_0020;
    bus.wdata = ~v_old;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.rdata !== 32'd0 || ram_addr !== '0) begin
      n_fail++; $display("[TB] FAIL midrst_outputs: got rdata %h ram_addr %h expected 0 0", bus.rdata, ram_addr);
    end
    n_checks++;
    if ({ram_we, bus.mio_ready, bus.bus_err} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL midrst_pulses: got %b expected 000", {ram_we, bus.mio_ready, bus.bus_err});
    end
    @(negedge clk);
    bus.mem_w = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_ram_we != s_ram) begin
      n_fail++; $display("[TB] FAIL midrst_no_write: got %0d strobes expected 0", n_ram_we - s_ram);
    end
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, rdv, rdv_after, errv, lat);
    n_checks++;
    if (rdv !== v_old || lat !== RAM_WAIT + 2) begin
      n_fail++; $display("[TB] FAIL midrst_after: got %h lat %0d expected %h lat %0d", rdv, lat, v_old, RAM_WAIT + 2);
    end
  endtask

  task automatic test_random();
    logic [31:0] rdv, rdv_after, a, d, exp_rd;
    logic errv, rd, wr, conflict, known, exp_err;
    logic [RAM_AW-1:0] idx;
    int lat, kind, reg_id, hold, s_ram, s_gpio, s_cnt, e_ram, e_gpio, e_cnt;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 8);
      conflict = ($urandom_range(0, 7) == 0);
      wr = conflict ? 1'b1 : 1'($urandom_range(0, 1));
      rd = conflict ? 1'b1 : !wr;
      d = $urandom;
      idx = RAM_AW'($urandom_range(0, 15));
      hold = $urandom_range(0, 2);
      if (kind <= 4) a = {4'h0, 16'($urandom), idx, 2'($urandom)};
      else if (kind <= 6) a = {4'hE, 28'($urandom)};
      else if (kind == 7) a = {4'hF, 28'($urandom)};
      else a = {4'($urandom_range(1, 13)), 28'($urandom)};
      reg_id = region_of(a);
      exp_err = conflict || (reg_id == 3);
      known = 1'b1;
      case (reg_id)
        0: begin known = exp_vld[idx]; exp_rd = exp_ram[idx]; end
        1: exp_rd = exp_gpio;
        2: exp_rd = exp_cnt;
        default: exp_rd = 32'd0;
      endcase
      e_ram  = (wr && reg_id == 0) ? 1 : 0;
      e_gpio = (wr && reg_id == 1) ? 1 : 0;
      e_cnt  = (wr && reg_id == 2) ? 1 : 0;
      s_ram = n_ram_we; s_gpio = n_gpio_we; s_cnt = n_cnt_we;
      do_access(rd, wr, a, d, hold, rdv, rdv_after, errv, lat);
      n_checks++;
      if (lat !== latency_of(a) || errv !== exp_err) begin
        n_fail++; $display("[TB] FAIL rand_lat_err[%0d] addr %h: got lat %0d err %b expected %0d %b", i, a, lat, errv, latency_of(a), exp_err);
      end
      n_checks++;
      if (n_ram_we - s_ram !== e_ram || n_gpio_we - s_gpio !== e_gpio || n_cnt_we - s_cnt !== e_cnt) begin
        n_fail++; $display("[TB] FAIL rand_strobes[%0d] addr %h: got %0d/%0d/%0d expected %0d/%0d/%0d", i, a, n_ram_we - s_ram, n_gpio_we - s_gpio, n_cnt_we - s_cnt, e_ram, e_gpio, e_cnt);
      end
      if (wr) begin
        case (reg_id)
          0: begin
            n_checks++;
            if (we_addr !== idx) begin
              n_fail++; $display("[TB] FAIL rand_ram_addr[%0d]: got %h expected %h", i, we_addr, idx);
            end
            exp_ram[idx] = d; exp_vld[idx] = 1'b1;
          end
          1: exp_gpio = d;
          2: exp_cnt = d;
          default: ;
        endcase
      end else if (known) begin
        n_checks++;
        if (rdv !== exp_rd || rdv_after !== exp_rd) begin
          n_fail++; $display("[TB] FAIL rand_rdata[%0d] addr %h: got %h/%h expected %h", i, a, rdv, rdv_after, exp_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_write_read();
    test_gpio_cnt();
    test_unmapped();
    test_hold_no_repeat();
    test_conflict();
    test_reset_mid_access();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
